cnt_bank_ctrl: RTL and testbench

Controller for a bank of NUM_CNT free-running wide counters with a pipelined zero-detect.
- Sequences counter enables with a staggered ramp, so all counters do not start on one edge.
- Issues a synchronous clear, takes atomic snapshots of all counters, and streams them out one word per valid/ready beat.
- Sits between the register/command logic and the counter datapath, in the counters' BUFG clock domain.

---
 rtl/cnt_bank_pkg.sv | 8 +
 rtl/cnt_bank_snap_stream.sv | 56 +++++
 rtl/cnt_bank_ctrl.sv | 91 +++++++++
 tb/tb_cnt_bank_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_bank_pkg.sv
// cnt_bank_pkg: shared state encodings and index-width helper for the counter bank controller
package cnt_bank_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, RUN} run_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cnt_bank_snap_stream.sv
// cnt_bank_snap_stream: coherent counter snapshot streamed out one word per valid/ready beat
module cnt_bank_snap_stream
  import cnt_bank_pkg::*;
#(
  parameter int NUM_CNT  = 3,
  parameter int CNT_BITS = 40
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_snap,
  input  logic [NUM_CNT*CNT_BITS-1:0]   cnt_bus,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [CNT_BITS-1:0]           rd_data,
  output logic [idx_w(NUM_CNT)-1:0]     rd_idx,
  output logic                          rd_last,
  output logic                          snap_busy
);
  localparam int IW = idx_w(NUM_CNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CNT - 1);
  rd_state_t state, state_nxt;
  logic [IW-1:0] idx_nxt;
  logic [CNT_BITS-1:0] snap_q [2**IW];
  logic take;
  assign take      = state == R_IDLE && cmd_snap;
  assign rd_valid  = state == R_DRAIN;
  assign snap_busy = rd_valid;
  assign rd_last   = rd_valid && rd_idx == LAST_IDX;
  assign rd_data   = rd_valid ? snap_q[rd_idx] : '0;
  // Capture all counters on one edge so the snapshot is atomic
  always_ff @(posedge clk)
    if (take)
      for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= cnt_bus[i*CNT_BITS +: CNT_BITS];
  // Readout state and index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= R_IDLE;
      rd_idx <= '0;
    end else begin
      state  <= state_nxt;
      rd_idx <= idx_nxt;
    end
  end
  // Start a stream from idle, advance the index on each transfer, stop after the last word
  always_comb begin
    state_nxt = state;
    idx_nxt   = rd_idx;
    if (take) begin
      state_nxt = R_DRAIN;
      idx_nxt   = '0;
    end else if (rd_valid && rd_ready) begin
      state_nxt = rd_last ? R_IDLE : R_DRAIN;
      idx_nxt   = rd_last ? '0 : rd_idx + IW'(1);
    end
  end
endmodule

// File: rtl/cnt_bank_ctrl.sv
// cnt_bank_ctrl: staggered enable ramp, clear/stop control, zero detect and snapshot readout for a counter bank
module cnt_bank_ctrl
  import cnt_bank_pkg::*;
#(
  parameter int NUM_CNT  = 3,
  parameter int CNT_BITS = 40,
  parameter int STAGGER  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_start,
  input  logic                        cmd_stop,
  input  logic                        cmd_clear,
  input  logic                        cmd_snap,
  input  logic [NUM_CNT*CNT_BITS-1:0] cnt_bus,
  output logic [NUM_CNT-1:0]          cnt_en,
  output logic                        cnt_clr,
  output logic                        running,
  output logic                        all_zero,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [CNT_BITS-1:0]         rd_data,
  output logic [idx_w(NUM_CNT)-1:0]   rd_idx,
  output logic                        rd_last,
  output logic                        snap_busy
);
  localparam int RW   = $clog2(NUM_CNT*STAGGER + 1);
  localparam int LAST = (NUM_CNT - 1) * STAGGER;
  run_state_t state, state_nxt;
  logic [RW-1:0] ramp, ramp_nxt;
  logic [NUM_CNT-1:0] en_nxt, nz_q;
  logic clr_nxt;
  // Command decode with clear > stop > start; the ramp counter paces enable turn-on
  always_comb begin
    state_nxt = state;
    ramp_nxt  = ramp;
    clr_nxt   = 1'b0;
    if (cmd_clear) begin
      state_nxt = IDLE;
      clr_nxt   = 1'b1;
    end else if (cmd_stop) begin
      state_nxt = IDLE;
    end else if (cmd_start && state == IDLE) begin
      state_nxt = LAST == 0 ? RUN : RAMP;
      ramp_nxt  = '0;
    end else if (state == RAMP) begin
      ramp_nxt  = ramp + RW'(1);
      state_nxt = 32'(ramp_nxt) == LAST ? RUN : RAMP;
    end
    for (int i = 0; i < NUM_CNT; i++)
      en_nxt[i] = state_nxt == RUN || (state_nxt == RAMP && 32'(ramp_nxt) >= i*STAGGER);
  end
  // Run state and registered enable/clear/running outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ramp    <= '0;
      cnt_en  <= '0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      ramp    <= ramp_nxt;
      cnt_en  <= en_nxt;
      cnt_clr <= clr_nxt;
      running <= state_nxt != IDLE;
    end
  end
  // Two-stage zero detect: per-counter OR-reduce, then NOR across the bank
  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q     <= '1;
      all_zero <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) nz_q[i] <= |cnt_bus[i*CNT_BITS +: CNT_BITS];
      all_zero <= ~|nz_q;
    end
  end
  cnt_bank_snap_stream #(.NUM_CNT(NUM_CNT), .CNT_BITS(CNT_BITS)) u_snap (
    .clk(clk),
    .reset(reset),
    .cmd_snap(cmd_snap),
    .cnt_bus(cnt_bus),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_idx(rd_idx),
    .rd_last(rd_last),
    .snap_busy(snap_busy)
  );
endmodule

// File: tb/tb_cnt_bank_ctrl.sv
// tb_cnt_bank_ctrl: vector table, corner sequences and randomized model check of cnt_bank_ctrl
module tb_cnt_bank_ctrl;
  import cnt_bank_pkg::*;
  localparam int N = 3;
  localparam int W = 40;
  localparam int IW = idx_w(N);
  logic clk = 1'b0;
  logic reset, cmd_start, cmd_stop, cmd_clear, cmd_snap, rd_ready;
  logic [N*W-1:0] cnt_bus;
  logic [N-1:0] cnt_en, cnt_en4;
  logic cnt_clr, running, all_zero, rd_valid, rd_last, snap_busy;
  logic cnt_clr4, running4, all_zero4, rd_valid4, rd_last4, snap_busy4;
  logic [W-1:0] rd_data, rd_data4;
  logic [IW-1:0] rd_idx, rd_idx4;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  cnt_bank_ctrl #(.NUM_CNT(N), .CNT_BITS(W), .STAGGER(1)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear),
    .cmd_snap(cmd_snap), .cnt_bus(cnt_bus), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .running(running),
    .all_zero(all_zero), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_idx(rd_idx),
    .rd_last(rd_last), .snap_busy(snap_busy)
  );
  cnt_bank_ctrl #(.NUM_CNT(N), .CNT_BITS(W), .STAGGER(4)) dut4 (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear),
    .cmd_snap(cmd_snap), .cnt_bus(cnt_bus), .cnt_en(cnt_en4), .cnt_clr(cnt_clr4), .running(running4),
    .all_zero(all_zero4), .rd_valid(rd_valid4), .rd_ready(rd_ready), .rd_data(rd_data4), .rd_idx(rd_idx4),
    .rd_last(rd_last4), .snap_busy(snap_busy4)
  );
  typedef struct {
    logic start, stop, clear;
    logic [N-1:0] en;
    logic run, clr;
    logic [N-1:0] en4;
  } vec_t;
  vec_t tbl [19];
  logic [W-1:0] dq [$];
  int iq [$];
  bit az_q [$];
  bit m_run, m_clr, busy;
  int m_t0;
  logic [N-1:0] exp_en, exp_en4;
  logic [W-1:0] w;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic s, p, c, input logic [N-1:0] en, input logic run, clr,
                              input logic [N-1:0] en4);
    vec_t v;
    v.start = s; v.stop = p; v.clear = c; v.en = en; v.run = run; v.clr = clr; v.en4 = en4;
    return v;
  endfunction
  function automatic logic [N*W-1:0] bus3(input logic [W-1:0] a, b, c);
    return {c, b, a};
  endfunction
  function automatic logic [N-1:0] ramp_exp(input bit run, input int c, t0, s);
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = run && c >= t0 + 1 + i*s;
    return e;
  endfunction
  task automatic chk_reset_vals;
    chk("rst_en", cnt_en, 0); chk("rst_clr", cnt_clr, 0); chk("rst_running", running, 0);
    chk("rst_all_zero", all_zero, 0); chk("rst_valid", rd_valid, 0); chk("rst_data", rd_data, 0);
    chk("rst_idx", rd_idx, 0); chk("rst_last", rd_last, 0); chk("rst_busy", snap_busy, 0);
  endtask
  initial begin
    tbl[0]  = mk(0,0,0, 3'b000,0,0, 3'b000);
    tbl[1]  = mk(1,0,0, 3'b000,0,0, 3'b000);
    tbl[2]  = mk(0,0,0, 3'b001,1,0, 3'b001);
    tbl[3]  = mk(0,0,0, 3'b011,1,0, 3'b001);
    tbl[4]  = mk(0,0,0, 3'b111,1,0, 3'b001);
    tbl[5]  = mk(0,0,0, 3'b111,1,0, 3'b001);
    tbl[6]  = mk(0,0,0, 3'b111,1,0, 3'b011);
    tbl[7]  = mk(0,0,0, 3'b111,1,0, 3'b011);
    tbl[8]  = mk(0,0,0, 3'b111,1,0, 3'b011);
    tbl[9]  = mk(0,0,0, 3'b111,1,0, 3'b011);
    tbl[10] = mk(0,1,0, 3'b111,1,0, 3'b111);
    tbl[11] = mk(1,0,0, 3'b000,0,0, 3'b000);
    tbl[12] = mk(0,1,0, 3'b001,1,0, 3'b001);
    tbl[13] = mk(1,0,0, 3'b000,0,0, 3'b000);
    tbl[14] = mk(0,0,0, 3'b001,1,0, 3'b001);
    tbl[15] = mk(0,0,0, 3'b011,1,0, 3'b001);
    tbl[16] = mk(1,1,1, 3'b111,1,0, 3'b001);
    tbl[17] = mk(0,0,0, 3'b000,0,1, 3'b000);
    tbl[18] = mk(0,0,0, 3'b000,0,0, 3'b000);
    reset = 1; cmd_start = 0; cmd_stop = 0; cmd_clear = 0; cmd_snap = 0; rd_ready = 0; cnt_bus = '0;
    step; step;
    chk_reset_vals;
    reset = 0;
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("tbl%0d_en", k), cnt_en, tbl[k].en);
      chk($sformatf("tbl%0d_running", k), running, tbl[k].run);
      chk($sformatf("tbl%0d_clr", k), cnt_clr, tbl[k].clr);
      chk($sformatf("tbl%0d_en4", k), cnt_en4, tbl[k].en4);
      cmd_start = tbl[k].start; cmd_stop = tbl[k].stop; cmd_clear = tbl[k].clear;
      step;
    end
    cmd_start = 0; cmd_stop = 0; cmd_clear = 0;
    cnt_bus = bus3(5, 6, 7);
    cmd_start = 1; step; cmd_start = 0;
    step; step; step;
    chk("z_running", running, 1); chk("z_en", cnt_en, 3'b111); chk("z_az_nonzero", all_zero, 0);
    cmd_clear = 1; cmd_stop = 1; cmd_start = 1; step;
    cmd_clear = 0; cmd_stop = 0; cmd_start = 0;
    chk("z_clr_t1", cnt_clr, 1); chk("z_en_t1", cnt_en, 0); chk("z_running_t1", running, 0);
    step;
    chk("z_clr_t2", cnt_clr, 0);
    cnt_bus = '0;
    step;
    chk("z_az_t3", all_zero, 0);
    step;
    chk("z_az_t4", all_zero, 1);
    rd_ready = 0; cnt_bus = bus3(1, 2, 3); cmd_snap = 1; step; cmd_snap = 0;
    cnt_bus = bus3(40'haa, 40'hbb, 40'hcc);
    for (int s = 0; s < 3; s++) begin
      chk("s_stall_valid", rd_valid, 1); chk("s_stall_idx", rd_idx, 0); chk("s_stall_data", rd_data, 1);
      chk("s_stall_last", rd_last, 0); chk("s_stall_busy", snap_busy, 1);
      cmd_snap = s == 1;
      step;
      cmd_snap = 0;
    end
    rd_ready = 1;
    for (int b = 0; b < 3; b++) begin
      chk("s_beat_valid", rd_valid, 1); chk("s_beat_idx", rd_idx, b); chk("s_beat_data", rd_data, b + 1);
      chk("s_beat_last", rd_last, b == 2);
      cmd_snap = b == 2;
      cnt_bus = bus3(W'($urandom), W'($urandom), W'($urandom));
      step;
      cmd_snap = 0;
    end
    chk("s_end_valid", rd_valid, 0); chk("s_end_busy", snap_busy, 0);
    step;
    chk("s_ignored_valid", rd_valid, 0);
    cnt_bus = bus3(40'h11, 40'h22, 40'h33); cmd_snap = 1; step; cmd_snap = 0;
    cnt_bus = '0;
    for (int b = 0; b < 3; b++) begin
      chk("s2_idx", rd_idx, b); chk("s2_data", rd_data, 40'h11 * (b + 1)); chk("s2_last", rd_last, b == 2);
      step;
    end
    chk("s2_end_valid", rd_valid, 0);
    rd_ready = 0; cnt_bus = bus3(4, 5, 6); cmd_snap = 1; step; cmd_snap = 0;
    rd_ready = 1; step;
    chk("r_mid_idx", rd_idx, 1); chk("r_mid_data", rd_data, 5);
    reset = 1; rd_ready = 0; step;
    chk_reset_vals;
    reset = 0; cnt_bus = bus3(7, 8, 9); cmd_snap = 1; step; cmd_snap = 0;
    chk("r_re_valid", rd_valid, 1); chk("r_re_idx", rd_idx, 0); chk("r_re_data", rd_data, 7);
    reset = 1; step; reset = 0;
    m_run = 0; m_clr = 0; m_t0 = 0;
    dq.delete(); iq.delete(); az_q.delete();
    az_q.push_back(0); az_q.push_back(0);
    for (int c = 0; c < 3000; c++) begin
      exp_en = ramp_exp(m_run, c, m_t0, 1);
      exp_en4 = ramp_exp(m_run, c, m_t0, 4);
      chk("rnd_en", cnt_en, exp_en); chk("rnd_en4", cnt_en4, exp_en4);
      chk("rnd_running", running, m_run); chk("rnd_clr", cnt_clr, m_clr);
      chk("rnd_all_zero", all_zero, az_q[0]);
      chk("rnd_valid", rd_valid, dq.size() > 0); chk("rnd_busy", snap_busy, dq.size() > 0);
      if (dq.size() > 0) begin
        chk("rnd_idx", rd_idx, iq[0]); chk("rnd_data", rd_data, dq[0]); chk("rnd_last", rd_last, iq[0] == N - 1);
      end
      cmd_start = $urandom_range(5) == 0;
      cmd_stop = $urandom_range(14) == 0;
      cmd_clear = $urandom_range(19) == 0;
      cmd_snap = $urandom_range(6) == 0;
      rd_ready = 1'($urandom_range(1));
      for (int i = 0; i < N; i++) begin
        w = $urandom_range(1) ? W'(0) : W'({$urandom, $urandom});
        cnt_bus[i*W +: W] = w;
      end
      busy = dq.size() > 0;
      if (busy && rd_ready) begin
        void'(dq.pop_front()); void'(iq.pop_front());
      end else if (cmd_snap && !busy) begin
        for (int i = 0; i < N; i++) begin
          dq.push_back(cnt_bus[i*W +: W]); iq.push_back(i);
        end
      end
      m_clr = cmd_clear;
      if (cmd_clear || cmd_stop) m_run = 0;
      else if (cmd_start && !m_run) begin
        m_run = 1; m_t0 = c;
      end
      void'(az_q.pop_front());
      az_q.push_back(cnt_bus == '0);
      step;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
